alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational ALU instance between two requesters, for example the EX stage and an address/branch-compare unit. Arbitration is round-robin with a valid/ready request handshake. Each requester has a one-deep registered response buffer, so results return a fixed 1 cycle after acceptance and are held under backpressure. Per-requester saturating grant counters are provided for performance debug.

Parameters:
DW, 32, operand and result width (ALU is fixed at 32; must stay 32)
OPW, 4, width of aluop_t from cpu_types_pkg
CNTW, 16, width of each grant counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
req_valid  in  2  request valid, bit i = requester i
req_ready  out  2  request accepted this cycle (one-hot or zero)
req_op  in  2xOPW  aluop_t per requester
req_a  in  2xDW  port_A operand per requester
req_b  in  2xDW  port_B operand per requester
rsp_valid  out  2  response buffer i holds a result
rsp_ready  in  2  requester i consumes its response this cycle
rsp_out  out  2xDW  buffered result
rsp_flags  out  2x3  buffered {overflow, zero, neg}
alu_op  out  OPW  to ALU alu_op
alu_a  out  DW  to ALU port_A
alu_b  out  DW  to ALU port_B
alu_out  in  DW  from ALU outport
alu_ovf  in  1  from ALU overflow
alu_zero  in  1  from ALU zero
alu_neg  in  1  from ALU neg
gnt_cnt  out  2xCNTW  saturating grant count per requester

Behaviour:
- Eligibility: elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). A buffer draining in the same cycle may be refilled in that cycle.
- Grant (combinational):
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, requester pri is granted.
  - If neither is eligible, there is no grant.
- req_ready = one-hot grant, forced to 0 while RST=1.
- ALU drive:
  - With a grant: alu_op/alu_a/alu_b = granted requester's op/a/b.
  - With no grant: all three driven to 0.
- Round-robin pointer pri (1 bit):
  - On any grant to i, pri <= ~i.
  - With no grant, pri holds.
  - Reset value is 0.
- Response capture: on the edge ending an accept cycle for i:
  - rsp_out[i] <= alu_out; rsp_flags[i] <= {alu_ovf, alu_zero, alu_neg}; rsp_valid[i] <= 1.
  - Latency is exactly 1 cycle from accept to rsp_valid.
- Response release: if rsp_valid[i] && rsp_ready[i] and no new accept for i, then rsp_valid[i] <= 0. rsp_out[i] and rsp_flags[i] hold their last value.
- Backpressure: while rsp_valid[i]=1 && rsp_ready[i]=0, rsp_out/rsp_flags[i] are stable and requester i is not granted. The other requester is unaffected.
- Counters: gnt_cnt[i] increments on each accept for i and saturates at 2^CNTW-1; it never wraps.
- Reset (synchronous, takes effect at the edge with RST=1, including mid-transaction):
  - rsp_valid=0, rsp_out=0, rsp_flags=0, pri=0, gnt_cnt=0.
  - A request presented during the RST cycle is not accepted, and no response is generated for it.
- Outputs in the first cycle after reset: req_ready reflects arbitration normally; alu_* = 0 if no request is valid.
- No combinational path from rsp_ready to rsp_out; rsp_ready→req_ready is combinational by design.

Test Plan:
- Single accept: req0 ADD a=0x7FFFFFFF, b=0x00000001 → req_ready=01 that cycle. Next cycle: rsp_valid=01, rsp_out[0]=0x80000000, flags {ovf=1, zero=0, neg=1}. gnt_cnt[0]=1.
- Contention: both valid continuously, rsp_ready=11. Requester 0 issues SUB 5-5, requester 1 issues SLT -1<0.
  - Grants alternate 0,1,0,1 starting with 0.
  - rsp_out[0]=0 with zero=1; rsp_out[1]=1.
  - gnt_cnt equal after 8 cycles (4/4).
- Backpressure: rsp_ready[0]=0, req0 issues two ORs back-to-back, req1 valid.
  - Second req0 is not accepted, and rsp_out[0] stays at the first OR result.
  - req1 is granted every cycle.
  - Raising rsp_ready[0] causes the second req0 to be accepted in that same cycle, with its response 1 cycle later.
- Same-cycle drain/refill: rsp_valid[1]=1, rsp_ready[1]=1, req1 issues SRL a=4, b=0xF0 → accepted that cycle, rsp_valid[1] stays 1, and rsp_out[1] becomes 0x0F next cycle.
- Reset mid-operation: assert RST in the cycle req0 is valid and a response is pending.
  - Next cycle: rsp_valid=00, gnt_cnt=0, pri=0.
  - No response is ever produced for that request.
- Counter saturation (CNTW=4 build): 20 accepts for req1 → gnt_cnt[1] stops at 0xF.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter sharing one combinational ALU between two
//                requesters, with a one-deep registered response buffer and a
//                saturating grant counter per requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
   parameter int DW   = 32,
   parameter int OPW  = 4,
   parameter int CNTW = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [1:0][OPW-1:0]  req_op,
   input  logic [1:0][DW-1:0]   req_a,
   input  logic [1:0][DW-1:0]   req_b,
   output logic [1:0]           rsp_valid,
   input  logic [1:0]           rsp_ready,
   output logic [1:0][DW-1:0]   rsp_out,
   output logic [1:0][2:0]      rsp_flags,
   output logic [OPW-1:0]       alu_op,
   output logic [DW-1:0]        alu_a,
   output logic [DW-1:0]        alu_b,
   input  logic [DW-1:0]        alu_out,
   input  logic                 alu_ovf,
   input  logic                 alu_zero,
   input  logic                 alu_neg,
   output logic [1:0][CNTW-1:0] gnt_cnt
);

   localparam logic [CNTW-1:0] c_CNT_MAX = '1;

   logic [1:0] w_elig;
   logic [1:0] w_gnt;
   logic       r_pri;

   // Eligibility and grant: a full buffer only blocks its requester when it is
   // not being drained this cycle, so drain and refill can share a cycle.
   always_comb begin
      w_elig = req_valid & (~rsp_valid | rsp_ready);
      w_gnt  = 2'b00;
      if (!RST) begin
         if (w_elig == 2'b11) begin
            w_gnt = r_pri ? 2'b10 : 2'b01;
         end else begin
            w_gnt = w_elig;
         end
      end
   end

   assign req_ready = w_gnt;

   // Route the granted requester onto the shared ALU; idle ALU sees zeros.
   always_comb begin
      alu_op = '0;
      alu_a  = '0;
      alu_b  = '0;
      if (w_gnt[0]) begin
         alu_op = req_op[0];
         alu_a  = req_a[0];
         alu_b  = req_b[0];
      end else if (w_gnt[1]) begin
         alu_op = req_op[1];
         alu_a  = req_a[1];
         alu_b  = req_b[1];
      end
   end

   // Round-robin pointer: after serving requester i, favour the other one.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pri <= 1'b0;
      end else if (w_gnt != 2'b00) begin
         r_pri <= w_gnt[0];
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      logic            r_valid;
      logic [DW-1:0]   r_out;
      logic [2:0]      r_flags;
      logic [CNTW-1:0] r_cnt;

      // Response buffer: capture on accept, clear when drained without refill;
      // data and flags are left untouched on release.
      always_ff @(posedge CLK) begin
         if (RST) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_flags <= '0;
         end else if (w_gnt[gi]) begin
            r_valid <= 1'b1;
            r_out   <= alu_out;
            r_flags <= {alu_ovf, alu_zero, alu_neg};
         end else if (r_valid && rsp_ready[gi]) begin
            r_valid <= 1'b0;
         end
      end

      // Grant counter for performance debug; sticks at all-ones.
      always_ff @(posedge CLK) begin
         if (RST) begin
            r_cnt <= '0;
         end else if (w_gnt[gi] && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign rsp_valid[gi] = r_valid;
      assign rsp_out[gi]   = r_out;
      assign rsp_flags[gi] = r_flags;
      assign gnt_cnt[gi]   = r_cnt;
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter. A bench-side ALU answers
//                the shared ALU port; a transaction-level model predicts grants,
//                ALU drive, buffered responses and grant counts every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

   localparam int DW   = 32;
   localparam int OPW  = 4;
   localparam int CNTW = 4;
   localparam int CMAX = (1 << CNTW) - 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [1:0][OPW-1:0]  req_op;
   logic [1:0][DW-1:0]   req_a;
   logic [1:0][DW-1:0]   req_b;
   logic [1:0]           rsp_valid;
   logic [1:0]           rsp_ready;
   logic [1:0][DW-1:0]   rsp_out;
   logic [1:0][2:0]      rsp_flags;
   logic [OPW-1:0]       alu_op;
   logic [DW-1:0]        alu_a;
   logic [DW-1:0]        alu_b;
   logic [DW-1:0]        alu_out;
   logic                 alu_ovf;
   logic                 alu_zero;
   logic                 alu_neg;
   logic [1:0][CNTW-1:0] gnt_cnt;

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.DW(DW), .OPW(OPW), .CNTW(CNTW)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_out(rsp_out), .rsp_flags(rsp_flags),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_ovf(alu_ovf), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .gnt_cnt(gnt_cnt)
   );

   always #5 CLK = ~CLK;

   // Reference ALU: returns {ovf, zero, neg, result}. Shifts move port_B by port_A.
   function automatic logic [34:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      logic        v;
      r = '0;
      v = 1'b0;
      case (op)
         OP_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
         OP_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLL: r = b << a[4:0];
         OP_SRL: r = b >> a[4:0];
         default: r = '0;
      endcase
      return {v, (r == 32'd0), r[31], r};
   endfunction

   assign {alu_ovf, alu_zero, alu_neg, alu_out} = alu_f(alu_op, alu_a, alu_b);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic            m_pri = 1'b0;
   logic [1:0]      m_rv  = 2'b00;
   logic [1:0][31:0] m_ro = '0;
   logic [1:0][2:0] m_rf  = '0;
   int              m_cnt [2] = '{0, 0};

   // Who wins this cycle: lone eligible requester, else the favoured one.
   function automatic logic [1:0] exp_grant(input logic rst, input logic [1:0] v,
                                            input logic [1:0] busy, input logic [1:0] rr,
                                            input logic pri);
      logic [1:0] e;
      for (int i = 0; i < 2; i++) e[i] = v[i] && (!busy[i] || rr[i]);
      if (rst) return 2'b00;
      if (e == 2'b11) return pri ? 2'b10 : 2'b01;
      return e;
   endfunction

   // Compare every cycle mid-period, then advance the model for the coming edge.
   always @(negedge CLK) begin
      logic [1:0]  g;
      logic [34:0] res;
      g = exp_grant(RST, req_valid, m_rv, rsp_ready, m_pri);
      chk("req_ready", req_ready, g);
      if (!RST) begin
         if (g == 2'b00) begin
            chk("alu_op_idle", alu_op, 0);
            chk("alu_a_idle", alu_a, 0);
            chk("alu_b_idle", alu_b, 0);
         end else begin
            chk("alu_op", alu_op, req_op[g[1]]);
            chk("alu_a", alu_a, req_a[g[1]]);
            chk("alu_b", alu_b, req_b[g[1]]);
         end
      end
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rsp_valid%0d", i), rsp_valid[i], m_rv[i]);
         chk($sformatf("rsp_out%0d", i), rsp_out[i], m_ro[i]);
         chk($sformatf("rsp_flags%0d", i), rsp_flags[i], m_rf[i]);
         chk($sformatf("gnt_cnt%0d", i), gnt_cnt[i], m_cnt[i]);
      end
      if (RST) begin
         m_pri <= 1'b0;
         m_rv  <= 2'b00;
         m_ro  <= '0;
         m_rf  <= '0;
         m_cnt <= '{0, 0};
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
               res = alu_f(req_op[i], req_a[i], req_b[i]);
               m_rv[i]  <= 1'b1;
               m_ro[i]  <= res[31:0];
               m_rf[i]  <= res[34:32];
               m_cnt[i] <= (m_cnt[i] >= CMAX) ? CMAX : m_cnt[i] + 1;
            end else if (m_rv[i] && rsp_ready[i]) begin
               m_rv[i] <= 1'b0;
            end
         end
         if (g != 2'b00) m_pri <= g[0];
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_op[i] = op;
      req_a[i]  = a;
      req_b[i]  = b;
   endtask

   task automatic do_reset();
      RST       = 1'b1;
      req_valid = 2'b00;
      cyc();
      RST = 1'b0;
   endtask

   initial begin
      RST       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      cyc();
      cyc();
      @(negedge CLK);
      chk("reset_rsp_valid", rsp_valid, 2'b00);
      chk("reset_gnt_cnt", gnt_cnt, 0);
      chk("reset_rsp_out", rsp_out, 0);
      RST = 1'b0;
      cyc();

      // Single accept with signed overflow.
      rsp_ready = 2'b11;
      req_valid = 2'b01;
      set_req(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
      @(negedge CLK);
      chk("t1_ready", req_ready, 2'b01);
      cyc();
      req_valid = 2'b00;
      @(negedge CLK);
      chk("t1_rsp_valid", rsp_valid, 2'b01);
      chk("t1_rsp_out", rsp_out[0], 32'h8000_0000);
      chk("t1_flags", rsp_flags[0], 3'b101);
      chk("t1_cnt", gnt_cnt[0], 1);
      cyc();

      // Contention: strict alternation starting with requester 0.
      do_reset();
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      set_req(0, OP_SUB, 32'd5, 32'd5);
      set_req(1, OP_SLT, 32'hFFFF_FFFF, 32'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         chk($sformatf("t2_grant%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
         cyc();
      end
      req_valid = 2'b00;
      @(negedge CLK);
      chk("t2_cnt0", gnt_cnt[0], 4);
      chk("t2_cnt1", gnt_cnt[1], 4);
      chk("t2_out0", rsp_out[0], 0);
      chk("t2_flags0", rsp_flags[0], 3'b010);
      chk("t2_out1", rsp_out[1], 1);
      cyc();

      // Backpressure on requester 0 while requester 1 keeps flowing.
      do_reset();
      rsp_ready = 2'b10;
      req_valid = 2'b11;
      set_req(0, OP_OR, 32'h0F0, 32'h00F);
      set_req(1, OP_ADD, 32'd1, 32'd2);
      @(negedge CLK);
      chk("t3_first", req_ready, 2'b01);
      cyc();
      set_req(0, OP_OR, 32'h100, 32'h001);
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         chk($sformatf("t3_block%0d", k), req_ready, 2'b10);
         chk($sformatf("t3_hold%0d", k), rsp_out[0], 32'h0FF);
         cyc();
      end
      rsp_ready = 2'b11;
      @(negedge CLK);
      chk("t3_release", req_ready, 2'b01);
      cyc();
      req_valid = 2'b00;
      @(negedge CLK);
      chk("t3_rsp_valid0", rsp_valid[0], 1'b1);
      chk("t3_second", rsp_out[0], 32'h101);
      cyc();

      // Same-cycle drain and refill on requester 1.
      rsp_ready = 2'b00;
      req_valid = 2'b10;
      set_req(1, OP_ADD, 32'd1, 32'd2);
      @(negedge CLK);
      chk("t4_fill", req_ready, 2'b10);
      cyc();
      rsp_ready = 2'b10;
      set_req(1, OP_SRL, 32'd4, 32'hF0);
      @(negedge CLK);
      chk("t4_refill", req_ready, 2'b10);
      chk("t4_old", rsp_out[1], 32'd3);
      cyc();
      req_valid = 2'b00;
      @(negedge CLK);
      chk("t4_valid", rsp_valid[1], 1'b1);
      chk("t4_new", rsp_out[1], 32'h0F);
      cyc();

      // Reset while a response is pending and a request is presented.
      do_reset();
      rsp_ready = 2'b00;
      req_valid = 2'b01;
      set_req(0, OP_OR, 32'h1, 32'h2);
      @(negedge CLK);
      chk("t5_pre", req_ready, 2'b01);
      cyc();
      RST = 1'b1;
      set_req(0, OP_ADD, 32'd7, 32'd8);
      @(negedge CLK);
      chk("t5_rst_ready", req_ready, 2'b00);
      cyc();
      RST       = 1'b0;
      req_valid = 2'b00;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         chk($sformatf("t5_norsp%0d", k), rsp_valid, 2'b00);
         chk($sformatf("t5_cnt%0d", k), gnt_cnt, 0);
         cyc();
      end
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      @(negedge CLK);
      chk("t5_pri", req_ready, 2'b01);
      cyc();

      // Counter saturation.
      do_reset();
      rsp_ready = 2'b11;
      req_valid = 2'b10;
      set_req(1, OP_XOR, 32'hA5, 32'h5A);
      repeat (20) cyc();
      req_valid = 2'b00;
      @(negedge CLK);
      chk("t6_sat", gnt_cnt[1], 4'hF);
      chk("t6_other", gnt_cnt[0], 0);
      cyc();

      // Randomized traffic with occasional resets.
      repeat (3000) begin
         RST       = ($urandom_range(0, 99) == 0);
         req_valid = 2'($urandom_range(0, 3));
         for (int i = 0; i < 2; i++) begin
            rsp_ready[i] = ($urandom_range(0, 9) < 7);
            req_op[i]    = 4'($urandom_range(0, 9));
            req_a[i]     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            req_b[i]     = ($urandom_range(0, 7) == 0) ? req_a[i] : $urandom;
         end
         cyc();
      end
      RST       = 1'b0;
      req_valid = 2'b00;
      cyc();
      @(negedge CLK);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
